mem_access_unit: RTL and testbench

- Initiator side of the S-Machine data-memory interface.
- Accepts load/store requests from the CPU execute stage over a valid/ready handshake.
- Sequences the memory's addr / read_write / data_in pins so every write is glitch-free and single-shot, then returns read data or an error.
- Also handles the memory-mapped devices: the LED at word 0 (bit 0) and the switch at word 4 (bit 0).

---
 rtl/mem_access_unit_pkg.sv | 23 ++
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 91 +++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the S-Machine data-memory initiator.
// Word-addressed memory with LED and switch mapped into low words.
package s_machine_pkg;

  localparam int DATA_W    = 16;
  localparam int MEM_AW    = 9;
  localparam int REQ_AW    = 16;
  localparam int MEM_DEPTH = 512;

  localparam logic [MEM_AW-1:0] LED_ADDR    = 9'd0;
  localparam logic [MEM_AW-1:0] SWITCH_ADDR = 9'd4;

  localparam logic [REQ_AW-1:0] MEM_LIMIT = REQ_AW'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    READ,
    RESP
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle of the memory access unit.
// master = execute stage, slave = memory access unit.
interface mem_access_if;
  import s_machine_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [REQ_AW-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_access_unit.sv
// Sequences addr / read_write / data_in so each write is one clean pulse.
// Memory pins and response are registered one cycle behind the state.
module mem_access_unit
  import s_machine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_access_if.slave       cpu,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_read_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mau_state_t        r_state;
  logic              r_write;
  logic              r_err;
  logic [MEM_AW-1:0] r_mem_addr;
  logic              r_mem_rw;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_in_range;

  assign w_in_range    = cpu.req_addr < MEM_LIMIT;
  assign cpu.req_ready = (r_state == IDLE) && !reset;

  assign mem_addr       = r_mem_addr;
  assign mem_read_write = r_mem_rw;
  assign mem_wdata      = r_mem_wdata;
  assign cpu.rsp_valid  = r_rsp_valid;
  assign cpu.rsp_rdata  = r_rsp_rdata;
  assign cpu.rsp_err    = r_rsp_err;

  // Request FSM; write strobe and response pulse default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rw    <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_mem_rw    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cpu.req_valid) begin
            r_write <= cpu.req_write;
            if (w_in_range) begin
              r_err      <= 1'b0;
              r_mem_addr <= cpu.req_addr[MEM_AW-1:0];
              if (cpu.req_write)
                r_mem_wdata <= cpu.req_wdata;
              r_state <= SETUP;
            end else begin
              r_err   <= 1'b1;
              r_state <= RESP;
            end
          end
        end
        SETUP: begin
          r_state <= r_write ? WRITE : READ;
        end
        WRITE: begin
          r_mem_rw <= 1'b1;
          r_state  <= RESP;
        end
        READ: begin
          r_rsp_rdata <= mem_rdata;
          r_state     <= RESP;
        end
        RESP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 512-word memory model.
// Word 0 bit 0 is the LED; word 4 reads back the switch.
module tb_mem_access_unit;
  import s_machine_pkg::*;

  logic              clk;
  logic              reset;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_read_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              sw;
  logic              mem_init;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              led;

  int n_vec;
  int n_err;

  mem_access_if bus ();

  mem_access_unit dut (
    .clk            (clk),
    .reset          (reset),
    .cpu            (bus.slave),
    .mem_addr       (mem_addr),
    .mem_read_write (mem_read_write),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: write on rising edge, combinational read
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= DATA_W'(16'h5A00 + i);
    end else if (mem_read_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign led = mem[0][0];
  assign mem_rdata = (mem_addr == SWITCH_ADDR)
                   ? {{(DATA_W-1){1'b0}}, sw}
                   : mem[mem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w,
                       input logic [REQ_AW-1:0] a,
                       input logic [DATA_W-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    mem_init = 1'b1;
    sw = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    tick();
    mem_init = 1'b0;
    tick();

    // reset state
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rw", 32'(mem_read_write), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);

    // store 0x0001 to LED word
    drive(1'b1, 16'h0000, 16'h0001);
    tick();
    bus.req_valid = 1'b0;
    chk("st_led_busy", 32'(bus.req_ready), 32'd0);
    tick();
    chk("st_led_rw_n1", 32'(mem_read_write), 32'd0);
    tick();
    chk("st_led_rw_n2", 32'(mem_read_write), 32'd1);
    chk("st_led_wd", 32'(mem_wdata), 32'h0001);
    chk("st_led_v_n2", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("st_led_rw_n3", 32'(mem_read_write), 32'd0);
    chk("st_led_v_n3", 32'(bus.rsp_valid), 32'd1);
    chk("st_led_err", 32'(bus.rsp_err), 32'd0);
    chk("st_led_rd", 32'(bus.rsp_rdata), 32'd0);
    chk("led_on", 32'(led), 32'd1);
    tick();
    chk("st_led_v_n4", 32'(bus.rsp_valid), 32'd0);

    // switch loads, both levels
    for (int s = 1; s >= 0; s--) begin
      sw = s[0];
      drive(1'b0, 16'h0004, 16'hFFFF);
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      chk("sw_v_n2", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("sw_v_n3", 32'(bus.rsp_valid), 32'd1);
      chk("sw_rdata", 32'(bus.rsp_rdata), 32'(s));
      chk("sw_err", 32'(bus.rsp_err), 32'd0);
      tick();
    end

    // store 0xBEEF to top word then load it, request held
    drive(1'b1, 16'h01FF, 16'hBEEF);
    tick();
    drive(1'b0, 16'h01FF, 16'h0000);
    tick();
    chk("b2b_rdy_n1", 32'(bus.req_ready), 32'd0);
    tick();
    chk("b2b_rdy_n2", 32'(bus.req_ready), 32'd0);
    tick();
    chk("b2b_rdy_n3", 32'(bus.req_ready), 32'd1);
    chk("b2b_st_v", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_mem", 32'(mem[9'h1FF]), 32'hBEEF);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_acc_n4", 32'(bus.req_ready), 32'd0);
    chk("b2b_addr", 32'(mem_addr), 32'h01FF);
    tick();
    tick();
    tick();
    chk("b2b_ld_v", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_ld_rd", 32'(bus.rsp_rdata), 32'hBEEF);
    tick();

    // out-of-range load
    drive(1'b0, 16'h0200, 16'h0000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("oor_v", 32'(bus.rsp_valid), 32'd1);
    chk("oor_err", 32'(bus.rsp_err), 32'd1);
    chk("oor_rw", 32'(mem_read_write), 32'd0);
    chk("oor_addr", 32'(mem_addr), 32'h01FF);
    chk("oor_rd", 32'(bus.rsp_rdata), 32'hBEEF);
    tick();
    chk("oor_v_off", 32'(bus.rsp_valid), 32'd0);
    chk("oor_err_off", 32'(bus.rsp_err), 32'd0);

    // reset during SETUP aborts a store
    drive(1'b1, 16'h0010, 16'h1234);
    tick();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort_rw", 32'(mem_read_write), 32'd0);
    chk("abort_rdy_rst", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_rdy", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_v", 32'(bus.rsp_valid), 32'd0);
      chk("abort_no_rw", 32'(mem_read_write), 32'd0);
    end
    chk("abort_mem", 32'(mem[9'h010]), 32'h5A10);

    // competing request while a load is in flight
    drive(1'b0, 16'h01FF, 16'h0000);
    tick();
    drive(1'b1, 16'h0020, 16'h7777);
    tick();
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("busy_v", 32'(bus.rsp_valid), 32'd1);
    chk("busy_rd", 32'(bus.rsp_rdata), 32'hBEEF);
    chk("busy_addr", 32'(mem_addr), 32'h01FF);
    tick();
    chk("busy_v_off", 32'(bus.rsp_valid), 32'd0);
    chk("busy_rdy", 32'(bus.req_ready), 32'd1);
    tick();
    chk("busy_rw", 32'(mem_read_write), 32'd0);
    chk("busy_mem", 32'(mem[9'h020]), 32'h5A20);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
